// File: rtl/alu_arbiter.sv
// Round-robin sequencer that lets two masters share one multi-cycle ALU without bus contention.
// Optional feature: define ALU_ARB_STATS_EN to add saturating per-master completion counters cnt0/cnt1.
module alu_arbiter #(
   parameter int ALU_LAT = 4,
   parameter int DW      = 16
) (
   input  logic          clk,
   input  logic          rst,
`ifdef ALU_ARB_STATS_EN
   output logic [15:0]   cnt0,
   output logic [15:0]   cnt1,
`endif
   input  logic          req0,
   input  logic [3:0]    op0,
   input  logic [DW-1:0] a0,
   input  logic [DW-1:0] b0,
   output logic          gnt0,
   output logic          done0,
   input  logic          req1,
   input  logic [3:0]    op1,
   input  logic [DW-1:0] a1,
   input  logic [DW-1:0] b1,
   output logic          gnt1,
   output logic          done1,
   output logic [DW-1:0] result,
   output logic          result_z,
   output logic          err,
   output logic          alu_enable,
   output logic [3:0]    alu_op,
   output logic [DW-1:0] alu_a,
   output logic [DW-1:0] alu_b,
   input  logic [DW-1:0] alu_c
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

   localparam logic [3:0] WAIT_INIT = 4'(ALU_LAT - 1);

   state_e        state_q;
   logic          rr_q;
   logic          owner_q;
   logic [3:0]    op_q;
   logic [DW-1:0] a_q;
   logic [DW-1:0] b_q;
   logic [3:0]    waitCnt_q;
   logic          gnt0_q;
   logic          gnt1_q;
   logic          done0_q;
   logic          done1_q;
   logic          err_q;
   logic          aluEn_q;
   logic [DW-1:0] result_q;
   logic          resultZ_q;

   logic          winner_d;
   logic [3:0]    op_d;
   logic [DW-1:0] a_d;
   logic [DW-1:0] b_d;

   function automatic logic isLegal(input logic [3:0] op);
      return (op >= 4'd1) && (op <= 4'd11);
   endfunction

   // A lone requester always wins; rr_q only breaks ties.
   always_comb begin
      winner_d = (req0 && req1) ? rr_q : req1;
      op_d     = winner_d ? op1 : op0;
      a_d      = winner_d ? a1  : a0;
      b_d      = winner_d ? b1  : b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         rr_q      <= 1'b0;
         owner_q   <= 1'b0;
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         waitCnt_q <= '0;
         gnt0_q    <= 1'b0;
         gnt1_q    <= 1'b0;
         done0_q   <= 1'b0;
         done1_q   <= 1'b0;
         err_q     <= 1'b0;
         aluEn_q   <= 1'b0;
         result_q  <= '0;
         resultZ_q <= 1'b0;
      end else begin
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         done0_q <= 1'b0;
         done1_q <= 1'b0;
         aluEn_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req0 || req1) begin
                  owner_q <= winner_d;
                  op_q    <= op_d;
                  a_q     <= a_d;
                  b_q     <= b_d;
                  gnt0_q  <= ~winner_d;
                  gnt1_q  <= winner_d;
                  aluEn_q <= isLegal(op_d);
                  state_q <= ISSUE;
               end
            end
            ISSUE: begin
               if (isLegal(op_q)) begin
                  waitCnt_q <= WAIT_INIT;
                  state_q   <= WAIT;
               end else begin
                  // Illegal opcodes never touch the ALU and complete with a zero result.
                  err_q     <= 1'b1;
                  result_q  <= '0;
                  resultZ_q <= 1'b1;
                  done0_q   <= ~owner_q;
                  done1_q   <= owner_q;
                  state_q   <= DONE;
               end
            end
            WAIT: begin
               if (waitCnt_q == 4'd0) begin
                  result_q  <= alu_c;
                  resultZ_q <= (alu_c == '0);
                  done0_q   <= ~owner_q;
                  done1_q   <= owner_q;
                  state_q   <= DONE;
               end else begin
                  waitCnt_q <= waitCnt_q - 4'd1;
               end
            end
            DONE: begin
               rr_q    <= ~owner_q;
               err_q   <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef ALU_ARB_STATS_EN
   logic [15:0] cnt0_q;
   logic [15:0] cnt1_q;

   // Counts every completion, legal or not, and sticks at all-ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else if (state_q == DONE) begin
         if (!owner_q && (cnt0_q != 16'hFFFF)) cnt0_q <= cnt0_q + 16'd1;
         if (owner_q && (cnt1_q != 16'hFFFF))  cnt1_q <= cnt1_q + 16'd1;
      end
   end

   assign cnt0 = cnt0_q;
   assign cnt1 = cnt1_q;
`endif

   assign gnt0       = gnt0_q;
   assign gnt1       = gnt1_q;
   assign done0      = done0_q;
   assign done1      = done1_q;
   assign err        = err_q;
   assign alu_enable = aluEn_q;
   assign alu_op     = op_q;
   assign alu_a      = a_q;
   assign alu_b      = b_q;
   assign result     = result_q;
   assign result_z   = resultZ_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a transaction-level timeline model plus a latency-accurate ALU stand-in.
// Directed scenarios pin the model with literal values, then randomized traffic runs against it.
module tb_alu_arbiter;

   localparam int LAT = 4;
   localparam int DW  = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0 = 1'b0, req1 = 1'b0;
   logic [3:0]    op0 = '0, op1 = '0;
   logic [DW-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
   logic          gnt0, gnt1, done0, done1, err, alu_enable, result_z;
   logic [3:0]    alu_op;
   logic [DW-1:0] result, alu_a, alu_b;
   logic [DW-1:0] alu_c = '0;
`ifdef ALU_ARB_STATS_EN
   logic [15:0]   cnt0, cnt1;
`endif

   always #5 clk = ~clk;

   alu_arbiter #(.ALU_LAT(LAT), .DW(DW)) dut (
      .clk(clk), .rst(rst),
`ifdef ALU_ARB_STATS_EN
      .cnt0(cnt0), .cnt1(cnt1),
`endif
      .req0(req0), .op0(op0), .a0(a0), .b0(b0), .gnt0(gnt0), .done0(done0),
      .req1(req1), .op1(op1), .a1(a1), .b1(b1), .gnt1(gnt1), .done1(done1),
      .result(result), .result_z(result_z), .err(err),
      .alu_enable(alu_enable), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_c(alu_c)
   );

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // Model: one planned transaction described by the cycles of its grant and its done pulse.
   int          grantCyc, doneCyc, nextSample;
   bit          owner, rr;
   logic [3:0]  pendOp, curOp;
   logic [15:0] pendA, pendB, curA, curB, pendRes, curRes;
   bit          curZ;
   int          mCnt0, mCnt1;

   int          obsGnt0, obsGnt1, obsDone0, obsDone1, enCount;
   logic [15:0] obsRes;
   bit          obsZ, obsErr;
   int          gntSeq[$];

   int          aluRemain = 0;
   logic [15:0] aluVal = '0;

   function automatic logic [15:0] aluRef(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      case (op)
         4'd1:    return a + b;
         4'd2:    return a - b;
         4'd3:    return a;
         4'd4:    return b;
         4'd5:    return a + 16'd1;
         4'd6:    return a - 16'd1;
         4'd7:    return a << 1;
         4'd8:    return a << 2;
         4'd9:    return a << 8;
         4'd10:   return a >> 4;
         default: return 16'd0;
      endcase
   endfunction

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] want);
      tests++;
      if (act !== want) begin
         fails++;
         $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, want, cyc);
      end
   endtask

   task automatic checkOutput();
      bit isDone;
      if (cyc == grantCyc) begin
         curOp = pendOp; curA = pendA; curB = pendB;
      end
      if (cyc == doneCyc) begin
         curRes = pendRes; curZ = (pendRes == 16'd0);
      end
      isDone = (cyc == doneCyc);
      checkVal("gnt",     32'({gnt0, gnt1}), 32'({(cyc == grantCyc) && !owner, (cyc == grantCyc) && owner}));
      checkVal("done",    32'({done0, done1}), 32'({isDone && !owner, isDone && owner}));
      checkVal("enable",  32'(alu_enable), 32'((cyc == grantCyc) && (pendOp >= 4'd1) && (pendOp <= 4'd11)));
      checkVal("err",     32'(err), 32'(isDone && !((pendOp >= 4'd1) && (pendOp <= 4'd11))));
      checkVal("result",  32'(result), 32'(curRes));
      checkVal("resultZ", 32'(result_z), 32'(curZ));
      checkVal("aluOp",   32'(alu_op), 32'(curOp));
      checkVal("aluA",    32'(alu_a), 32'(curA));
      checkVal("aluB",    32'(alu_b), 32'(curB));
`ifdef ALU_ARB_STATS_EN
      if (cyc == doneCyc + 1) begin
         if (owner) mCnt1 = (mCnt1 < 65535) ? mCnt1 + 1 : mCnt1;
         else       mCnt0 = (mCnt0 < 65535) ? mCnt0 + 1 : mCnt0;
      end
      checkVal("cnt0", 32'(cnt0), 32'(mCnt0));
      checkVal("cnt1", 32'(cnt1), 32'(mCnt1));
`endif
   endtask

   // One clock: sample outputs mid-cycle, record observations, run the ALU stand-in, retire granted requests.
   task automatic tick();
      @(posedge clk);
      cyc++;
      @(negedge clk);
      checkOutput();
      if (gnt0) begin obsGnt0 = cyc; gntSeq.push_back(0); end
      if (gnt1) begin obsGnt1 = cyc; gntSeq.push_back(1); end
      if (done0) begin obsDone0 = cyc; obsRes = result; obsZ = result_z; obsErr = err; end
      if (done1) begin obsDone1 = cyc; obsRes = result; obsZ = result_z; obsErr = err; end
      if (alu_enable) enCount++;
      if (aluRemain > 0) begin
         aluRemain--;
         alu_c = (aluRemain == 0) ? aluVal : 16'($urandom);
      end else begin
         alu_c = 16'($urandom);
      end
      if (alu_enable) begin
         aluRemain = LAT;
         aluVal    = aluRef(alu_op, alu_a, alu_b);
      end
      if (cyc == grantCyc) begin
         if (owner) req1 = 1'b0;
         else       req0 = 1'b0;
      end
   endtask

   // Decide what the coming edge does: arbitrate if the arbiter is free and someone asks.
   task automatic modelStep();
      int e;
      bit w;
      e = cyc + 1;
      if ((e >= nextSample) && (req0 || req1)) begin
         w        = (req0 && req1) ? rr : req1;
         owner    = w;
         grantCyc = e;
         pendOp   = w ? op1 : op0;
         pendA    = w ? a1 : a0;
         pendB    = w ? b1 : b0;
         if ((pendOp >= 4'd1) && (pendOp <= 4'd11)) begin
            doneCyc = e + LAT + 1;
            pendRes = aluRef(pendOp, pendA, pendB);
         end else begin
            doneCyc = e + 1;
            pendRes = 16'd0;
         end
         nextSample = doneCyc + 2;
         rr         = !w;
      end
   endtask

   task automatic advance();
      modelStep();
      tick();
   endtask

   task automatic raise(input bit w, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      if (w) begin req1 = 1'b1; op1 = op; a1 = a; b1 = b; end
      else   begin req0 = 1'b1; op0 = op; a0 = a; b0 = b; end
   endtask

   task automatic applyStimulus();
      logic [15:0] ra, rb;
      for (int m = 0; m < 2; m++) begin
         ra = 16'($urandom);
         rb = ($urandom_range(0, 7) == 0) ? ra : 16'($urandom);
         if (!(m == 0 ? req0 : req1)) begin
            if ($urandom_range(0, 3) == 0) raise(m[0], 4'($urandom_range(0, 15)), ra, rb);
         end else if ($urandom_range(0, 39) == 0) begin
            if (m == 0) req0 = 1'b0;
            else        req1 = 1'b0;
         end
      end
   endtask

   task automatic doReset();
      #2;
      rst  = 1'b1;
      req0 = 1'b0;
      req1 = 1'b0;
      #1;
      checkVal("rstCtl",    32'({gnt0, gnt1, done0, done1, err, alu_enable, result_z}), 32'd0);
      checkVal("rstResult", 32'(result), 32'd0);
      checkVal("rstAluOpA", 32'({alu_op, alu_a}), 32'd0);
      checkVal("rstAluB",   32'(alu_b), 32'd0);
      aluRemain = 0;
      repeat (2) begin
         @(posedge clk);
         cyc++;
      end
      @(negedge clk);
      rst        = 1'b0;
      grantCyc   = -100;
      doneCyc    = -100;
      nextSample = cyc + 1;
      owner      = 1'b0;
      rr         = 1'b0;
      pendOp = '0; curOp = '0; pendA = '0; pendB = '0; curA = '0; curB = '0;
      pendRes = '0; curRes = '0; curZ = 1'b0;
      mCnt0 = 0; mCnt1 = 0;
   endtask

   initial begin
      obsGnt0 = -1; obsGnt1 = -1; obsDone0 = -1; obsDone1 = -1; enCount = 0;
      obsRes = '0; obsZ = 1'b0; obsErr = 1'b0;
      doReset();

      // Single ADD from master 0.
      enCount = 0;
      raise(1'b0, 4'd1, 16'h0010, 16'h0005);
      repeat (10) advance();
      checkVal("t1Latency", 32'(obsDone0 - obsGnt0), 32'd5);
      checkVal("t1Result",  32'(obsRes), 32'h0015);
      checkVal("t1Z",       32'(obsZ), 32'd0);
      checkVal("t1Enable",  32'(enCount), 32'd1);

      // Simultaneous requests straight after reset: master 0 first.
      doReset();
      raise(1'b0, 4'd2, 16'h0007, 16'h0007);
      raise(1'b1, 4'd2, 16'h0007, 16'h0007);
      repeat (20) advance();
      checkVal("t2Order",   32'(obsGnt0 < obsGnt1), 32'd1);
      checkVal("t2Spacing", 32'(obsDone1 - obsDone0), 32'd7);
      checkVal("t2Result",  32'(obsRes), 32'h0000);
      checkVal("t2Z",       32'(obsZ), 32'd1);

      // Master 0 keeps asking; master 1 arrives mid-operation and must get the next turn.
      doReset();
      gntSeq.delete();
      raise(1'b0, 4'd5, 16'h1234, 16'h0000);
      repeat (3) advance();
      raise(1'b1, 4'd9, 16'h00AB, 16'h0000);
      repeat (25) begin
         if (!req0) raise(1'b0, 4'd5, 16'($urandom), 16'($urandom));
         advance();
      end
      req0 = 1'b0;
      repeat (12) advance();
      checkVal("t3SeqLen", 32'(gntSeq.size() >= 3), 32'd1);
      checkVal("t3Seq", 32'({(gntSeq.size() > 0) ? gntSeq[0] : 9, (gntSeq.size() > 1) ? gntSeq[1] : 9,
                             (gntSeq.size() > 2) ? gntSeq[2] : 9}), 32'({32'd0, 32'd1, 32'd0}));

      // Illegal opcode on master 1.
      enCount = 0;
      raise(1'b1, 4'hE, 16'h5555, 16'hAAAA);
      repeat (6) advance();
      checkVal("t4Latency", 32'(obsDone1 - obsGnt1), 32'd1);
      checkVal("t4Err",     32'(obsErr), 32'd1);
      checkVal("t4Result",  32'(obsRes), 32'd0);
      checkVal("t4Enable",  32'(enCount), 32'd0);

      // Reset in the middle of an operation, then a clean PASSA.
      raise(1'b0, 4'd1, 16'h0101, 16'h0202);
      repeat (3) advance();
      obsDone0 = -1;
      doReset();
      repeat (6) advance();
      checkVal("t5NoDone", 32'(obsDone0), 32'hFFFF_FFFF);
      raise(1'b0, 4'd3, 16'hABCD, 16'h0F0F);
      repeat (8) advance();
      checkVal("t5Result", 32'(obsRes), 32'h0000_ABCD);

      // Randomized traffic.
      repeat (3000) begin
         applyStimulus();
         advance();
      end
      req0 = 1'b0;
      req1 = 1'b0;
      repeat (12) advance();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
